// File: rtl/sort_pkg.sv
// sort_pkg: shared constants, FSM states and RLE record type for the sort pipeline.
package sort_pkg;
  localparam int DEPTH = 16;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 5;
  typedef enum logic [2:0] {IDLE, FETCH, RUN, FLUSH, FIN} state_t;
  typedef struct packed {
    logic [DW-1:0] value;
    logic [CW-1:0] count;
  } rle_rec_t;
endpackage

// File: rtl/rle_accum.sv
// rle_accum: current-run value/count pair with compare/emit logic.
// Order check built only with SORTED_RLE_CHECK_ORDER_EN.
module rle_accum
  import sort_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_i,
  input  logic          first_i,
  input  logic [DW-1:0] d_i,
  output logic          emit_o,
  output rle_rec_t      rec_o,
  output logic          err_o
);
  logic [DW-1:0] cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign emit_o = sample_i && !first_i && d_i != cur_q;
  assign rec_o = '{value: cur_q, count: cnt_q};
`ifdef SORTED_RLE_CHECK_ORDER_EN
  assign err_o = sample_i && !first_i && d_i < cur_q;
`else
  assign err_o = 1'b0;
`endif
  always_comb begin
    cur_d = sample_i ? d_i : cur_q;
    cnt_d = !sample_i ? cnt_q : (first_i || d_i != cur_q) ? CW'(1) : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sorted_rle.sv
// sorted_rle: run-length encodes the sorted RAM into {value,count} records.
// Optional SORTED_RLE_CHECK_ORDER_EN flags descending neighbours on sort_err.
module sorted_rle
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             SRAM_rd,
  output logic [AW-1:0]    SRAM_A,
  input  logic [DW-1:0]    SRAM_Q,
  output logic             ORAM_valid,
  output logic [AW-1:0]    ORAM_A,
  output logic [DW+CW-1:0] ORAM_D,
  output logic [CW-1:0]    uniq_cnt,
  output logic             done,
  output logic             sort_err
);
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, idx_q, idx_d, wr_q, wr_d, oa_q, oa_d;
  logic rd_q, rd_d, ov_q, ov_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] uniq_q, uniq_d;
  rle_rec_t od_q, od_d, rec;
  logic sample, first, emit, acc_err;
  rle_accum u_acc (
    .clk(clk), .reset(reset), .sample_i(sample), .first_i(first),
    .d_i(SRAM_Q), .emit_o(emit), .rec_o(rec), .err_o(acc_err)
  );
  assign SRAM_rd = rd_q;
  assign SRAM_A = addr_q;
  assign ORAM_valid = ov_q;
  assign ORAM_A = oa_q;
  assign ORAM_D = od_q;
  assign uniq_cnt = uniq_q;
  assign done = done_q;
  assign sort_err = err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rd_d = rd_q;
    idx_d = idx_q;
    wr_d = wr_q;
    ov_d = 1'b0;
    oa_d = oa_q;
    od_d = od_q;
    uniq_d = uniq_q;
    done_d = done_q;
    err_d = err_q | acc_err;
    sample = 1'b0;
    first = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        // done_q gates FIN so a start on the FIN entry edge is ignored
        if (start && (state_q == IDLE || done_q)) begin
          done_d = 1'b0;
          uniq_d = '0;
          err_d = 1'b0;
          rd_d = 1'b1;
          addr_d = '0;
          wr_d = '0;
          state_d = FETCH;
        end else if (state_q == FIN) begin
          done_d = 1'b1;
          uniq_d = CW'(wr_q) + 1'b1;
        end
      end
      FETCH: begin
        addr_d = AW'(1);
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sample = 1'b1;
        first = idx_q == '0;
        addr_d = addr_q == AW'(DEPTH-1) ? addr_q : addr_q + 1'b1;
        rd_d = addr_q != AW'(DEPTH-1);
        idx_d = idx_q + 1'b1;
        state_d = idx_q == AW'(DEPTH-1) ? FLUSH : RUN;
        if (emit) begin
          ov_d = 1'b1;
          oa_d = wr_q;
          od_d = rec;
          wr_d = wr_q + 1'b1;
        end
      end
      FLUSH: begin
        ov_d = 1'b1;
        oa_d = wr_q;
        od_d = rec;
        state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rd_q <= 1'b0;
      idx_q <= '0;
      wr_q <= '0;
      ov_q <= 1'b0;
      oa_q <= '0;
      od_q <= '0;
      uniq_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      ov_q <= ov_d;
      oa_q <= oa_d;
      od_q <= od_d;
      uniq_q <= uniq_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_sorted_rle.sv
// tb_sorted_rle: directed self-checking bench for sorted_rle.
module tb_sorted_rle;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic SRAM_rd, ORAM_valid, done, sort_err;
  logic [3:0] SRAM_A, ORAM_A;
  logic [7:0] SRAM_Q;
  logic [12:0] ORAM_D;
  logic [4:0] uniq_cnt;
  logic [7:0] mem [16];
  logic [3:0] la [256];
  logic [12:0] ld [256];
  int lt [256];
  int wn = 0, cyc = 0, e0 = 0, base = 0, hold = 0;
  int n_cmp = 0, n_bad = 0;
`ifdef SORTED_RLE_CHECK_ORDER_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  sorted_rle dut (
    .clk(clk), .reset(reset), .start(start), .SRAM_rd(SRAM_rd), .SRAM_A(SRAM_A),
    .SRAM_Q(SRAM_Q), .ORAM_valid(ORAM_valid), .ORAM_A(ORAM_A), .ORAM_D(ORAM_D),
    .uniq_cnt(uniq_cnt), .done(done), .sort_err(sort_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (SRAM_rd) SRAM_Q <= mem[SRAM_A];
    if (ORAM_valid && wn < 255) begin
      la[wn] <= ORAM_A;
      ld[wn] <= ORAM_D;
      lt[wn] <= cyc;
      wn <= wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e0 = cyc - 1;
    base = wn;
  endtask

  // park at the negedge following edge Ek of the current run
  task automatic wait_edge(input int k);
    while (cyc - 1 - e0 < k) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"}, SRAM_rd, 0);
    chk({tag, "_A"}, SRAM_A, 0);
    chk({tag, "_ov"}, ORAM_valid, 0);
    chk({tag, "_oa"}, ORAM_A, 0);
    chk({tag, "_od"}, ORAM_D, 0);
    chk({tag, "_uniq"}, uniq_cnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, sort_err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle("rst");
    reset = 1'b1;

    for (int k = 0; k < 16; k++) mem[k] = 8'(k);
    run_start();
    wait_edge(18);
    chk("dist_done_e18", done, 0);
    wait_edge(19);
    chk("dist_done_e19", done, 1);
    chk("dist_uniq", uniq_cnt, 16);
    chk("dist_nrec", wn - base, 16);
    chk("dist_t0", lt[base] - e0, 4);
    chk("dist_t15", lt[base+15] - e0, 19);
    chk("dist_err", sort_err, 0);
    for (int k = 0; k < 16; k++) begin
      chk("dist_a", la[base+k], k);
      chk("dist_d", ld[base+k], {8'(k), 5'd1});
    end

    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd5; mem[3] = 8'd4;
    for (int k = 4; k < 16; k++) mem[k] = 8'(k + 2);
    run_start();
    wait_edge(4);
    chk("ord_err_e4", sort_err, 0);
    wait_edge(5);
    chk("ord_err_e5", sort_err, EXP_ERR);
    wait_edge(19);
    chk("ord_done", done, 1);
    chk("ord_uniq", uniq_cnt, 16);
    chk("ord_rec2", ld[base+2], {8'd5, 5'd1});
    chk("ord_rec3", ld[base+3], {8'd4, 5'd1});
    chk("ord_err_end", sort_err, EXP_ERR);

    for (int k = 0; k < 16; k++) mem[k] = 8'h55;
    run_start();
    chk("eq_err_clr", sort_err, 0);
    chk("eq_done_clr", done, 0);
    chk("eq_rd", SRAM_rd, 1);
    wait_edge(18);
    chk("eq_nrec_e18", wn - base, 0);
    chk("eq_ov_e18", ORAM_valid, 1);
    wait_edge(19);
    chk("eq_ov_e19", ORAM_valid, 0);
    chk("eq_nrec", wn - base, 1);
    chk("eq_a", la[base], 0);
    chk("eq_d", ld[base], {8'h55, 5'd16});
    chk("eq_t", lt[base] - e0, 19);
    chk("eq_uniq", uniq_cnt, 1);
    chk("eq_done", done, 1);

    mem[0] = 8'd3; mem[1] = 8'd3; mem[2] = 8'd3; mem[3] = 8'd7; mem[4] = 8'd7;
    for (int k = 5; k < 15; k++) mem[k] = 8'd9;
    mem[15] = 8'hFF;
    run_start();
    wait_edge(4);
    start = 1'b1;
    wait_edge(5);
    start = 1'b0;
    wait_edge(18);
    chk("mix_done_e18", done, 0);
    start = 1'b1;
    wait_edge(19);
    start = 1'b0;
    chk("mix_done_e19", done, 1);
    wait_edge(22);
    chk("mix_done_hold", done, 1);
    chk("mix_rd", SRAM_rd, 0);
    chk("mix_nrec", wn - base, 4);
    chk("mix_uniq", uniq_cnt, 4);
    chk("mix_r0", {la[base], ld[base]}, {4'd0, 8'd3, 5'd3});
    chk("mix_r1", {la[base+1], ld[base+1]}, {4'd1, 8'd7, 5'd2});
    chk("mix_r2", {la[base+2], ld[base+2]}, {4'd2, 8'd9, 5'd10});
    chk("mix_r3", {la[base+3], ld[base+3]}, {4'd3, 8'hFF, 5'd1});
    run_start();
    chk("mix2_done_clr", done, 0);
    chk("mix2_uniq_clr", uniq_cnt, 0);
    wait_edge(19);
    chk("mix2_done", done, 1);
    chk("mix2_uniq", uniq_cnt, 4);
    chk("mix2_nrec", wn - base, 4);
    chk("mix2_r2", ld[base+2], {8'd9, 5'd10});

    for (int k = 0; k < 16; k++) mem[k] = 8'(k);
    run_start();
    wait_edge(7);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("mid");
    hold = wn;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_nowr", wn, hold);
    chk("mid_done", done, 0);
    chk("mid_rd", SRAM_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sorted_rle.md
Name: sorted_rle

Overview:
- Downstream of the heap-sort stage. On `start`, it reads the DEPTH ascending-sorted bytes from the sort stage's result RAM, addresses 0..DEPTH-1.
- It run-length-encodes equal neighbours and writes one {value,count} record per distinct value into a result RAM.
- It reports the distinct-value count and asserts `done`. This is the final compaction/statistics stage of the sort pipeline.

Parameters:
- DEPTH, 16, number of elements read per run.
- DW, 8, element width.
- AW, 4, address width; DEPTH = 2**AW.
- CW, 5, run-count width; must hold DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  single-cycle request; wired to the sort stage's done.
- SRAM_rd  output  1  read enable to sorted RAM.
- SRAM_A  output  AW  read address.
- SRAM_Q  input  DW  read data; valid the cycle after SRAM_A is driven.
- ORAM_valid  output  1  write strobe to result RAM; one-cycle pulse per record.
- ORAM_A  output  AW  record address, 0 upward.
- ORAM_D  output  DW+CW  record {value[DW+CW-1:CW], count[CW-1:0]}.
- uniq_cnt  output  CW  number of records written in the last run.
- done  output  1  level-high when the run is finished.
- sort_err  output  1  sticky order-violation flag (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-low, clears all state.
  - Reset values: SRAM_rd=0, SRAM_A=0, ORAM_valid=0, ORAM_A=0, ORAM_D=0, uniq_cnt=0, done=0, sort_err=0, state=IDLE.
  - Reset asserted mid-run aborts immediately. No further ORAM writes occur, and the run is not resumed after release.
- States:
  - IDLE: waits for start.
  - FETCH: issues address 0.
  - RUN: DEPTH sample cycles.
  - FLUSH: writes the last record.
  - FIN: done high, waits for the next start.
- Start handling:
  - start is sampled in IDLE and FIN only; ignored in FETCH/RUN/FLUSH.
  - On a start edge (E0): done<=0, uniq_cnt<=0, sort_err<=0, SRAM_rd<=1, SRAM_A<=0, go to FETCH.
- FETCH, edge E1: SRAM_A<=1, go to RUN.
- RUN, element i (0..DEPTH-1) sampled from SRAM_Q at edge E(i+2):
  - SRAM_A increments each edge while SRAM_A < DEPTH-1, then holds. SRAM_rd drops after the last address is issued.
  - i=0: cur<=SRAM_Q, cnt<=1, no write.
  - i>0 and SRAM_Q==cur: cnt<=cnt+1, no write.
  - i>0 and SRAM_Q!=cur:
    - Emit ORAM_valid=1, ORAM_A=wr_ptr, ORAM_D={cur,cnt}.
    - wr_ptr<=wr_ptr+1; cur<=SRAM_Q; cnt<=1.
  - After i=DEPTH-1 is sampled, go to FLUSH.
- FLUSH, edge E(DEPTH+2): emit the final record {cur,cnt} at wr_ptr, then go to FIN.
- FIN, edge E(DEPTH+3):
  - done<=1, uniq_cnt<=wr_ptr+1 (total records).
  - done holds until the next accepted start.
- ORAM_valid is high for exactly one cycle per record. ORAM_A and ORAM_D are stable while valid and hold their last value otherwise.
- Width and wrap rules:
  - A count of DEPTH (all elements equal) requires CW bits; count never wraps.
  - wr_ptr ranges 0..DEPTH-1 and never wraps, since records ≤ DEPTH.
  - uniq_cnt ranges 1..DEPTH.
- Comparisons are unsigned.
- start coincident with the FIN entry edge is ignored; start is accepted from the following cycle.
- Records are ordered by ascending value.

Optional Feature:
- Macro: SORTED_RLE_CHECK_ORDER_EN.
- Defined: in RUN, for i>0, if SRAM_Q < cur then sort_err<=1.
  - The flag is sticky until the next accepted start or reset.
  - Encoding continues unchanged and treats the element as a new run.
- Undefined: sort_err is tied to 0 and no comparator is built.

Decomposition:
- Shared package sort_pkg holds:
  - DEPTH, DW, AW, CW constants.
  - State enum {IDLE, FETCH, RUN, FLUSH, FIN}.
  - Record type rle_rec_t {value, count}.
- One natural sub-module: rle_accum, the cur/cnt register pair with compare/emit logic. The top keeps the FSM and address counters.

Test Plan:
- RAM = 0x00..0x0F distinct → 16 records: ORAM_A k gets {k,1}; uniq_cnt=16; done at E19.
- All 16 = 0x55 → exactly one write at FLUSH: ORAM_A=0, D={0x55,16}; uniq_cnt=1.
- RAM = {3,3,3,7,7,9×10,0xFF} → records {3,3},{7,2},{9,10},{0xFF,1} at A=0..3; uniq_cnt=4.
- start pulsed again during RUN → ignored: same records and timing; a second start in FIN begins a new run and clears done.
- reset driven low at E8 then released → all outputs at reset values, no ORAM_valid afterwards until a new start.
- With SORTED_RLE_CHECK_ORDER_EN: RAM {1,2,5,4,...} → sort_err=1 from the E5 edge on, records include {5,1},{4,..}. Without the macro, sort_err stays 0.
